// File: rtl/memory_access_unit_pkg.sv
// Shared encodings for the memory access unit: data-memory access sizes,
// FSM states, the registered request record and a misalignment helper.
package memory_access_unit_pkg;

    typedef enum logic [1:0] {
        DM_NONE  = 2'd0,
        DM_BYTE  = 2'd1,
        DM_HWORD = 2'd2,
        DM_WORD  = 2'd3
    } dm_size_e;

    typedef enum logic [1:0] {
        MAU_IDLE   = 2'd0,
        MAU_ACCESS = 2'd1,
        MAU_RESP   = 2'd2
    } mau_state_e;

    // Everything the response path needs once the bus outputs are launched.
    typedef struct packed {
        logic       is_load;
        dm_size_e   size;
        logic       load_signed;
        logic [1:0] offset;
    } mau_req_t;

    function automatic logic is_misaligned(input dm_size_e size, input logic [1:0] offset);
        logic result;
        result = 1'b0;
        case (size)
            DM_HWORD: result = offset[0];
            DM_WORD:  result = (offset != 2'b00);
            default:  result = 1'b0;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/memory_access_unit_load_align.sv
// Combinational load extractor: picks the addressed byte/half out of a read
// word and sign- or zero-extends it to 32 bits.
module memory_access_unit_load_align
    import memory_access_unit_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  dm_size_e    size,
    input  logic        load_signed,
    output logic [31:0] result
);

    logic [7:0]  lane [4];
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign lane[gi] = rdata[8*gi +: 8];
    end

    assign byte_sel = lane[offset];
    assign half_sel = offset[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        result = '0;
        case (size)
            DM_BYTE:  result = {{24{load_signed & byte_sel[7]}}, byte_sel};
            DM_HWORD: result = {{16{load_signed & half_sel[15]}}, half_sel};
            DM_WORD:  result = rdata;
            default:  result = '0;
        endcase
    end

endmodule

// File: rtl/memory_access_unit.sv
// Load/store stage: runs one data-memory transaction over a req/ready bus and
// returns the extended load result. Optional MISALIGN_TRAP_EN traps misaligned accesses.
module memory_access_unit
    import memory_access_unit_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int ADDR_WIDTH     = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [1:0]            read_status,
    input  logic [1:0]            write_status,
    input  logic                  load_signed,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [31:0]           store_data,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic [3:0]            mem_wstrb,
    input  logic                  mem_ready,
    input  logic [31:0]           mem_rdata,
    output logic [31:0]           load_data,
    output logic                  done,
    output logic                  busy,
    output logic                  bus_error
);

    localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LIM = CNT_W'(TIMEOUT_CYCLES);

    mau_state_e            state_reg, state_next;
    mau_req_t              req_reg;
    logic                  mem_we_reg;
    logic [ADDR_WIDTH-1:0] mem_addr_reg;
    logic [31:0]           mem_wdata_reg;
    logic [3:0]            mem_wstrb_reg;
    logic [31:0]           load_data_reg;
    logic                  err_reg;
    logic [CNT_W-1:0]      wait_cnt_reg;

    dm_size_e    rd_size, wr_size, size_in;
    logic        is_load_in, has_op, misaligned_in, timeout_hit;
    logic [31:0] wdata_in;
    logic [3:0]  wstrb_in;
    logic [31:0] aligned_result;

    // A load takes precedence when the decoder flags both directions.
    assign rd_size    = dm_size_e'(read_status);
    assign wr_size    = dm_size_e'(write_status);
    assign is_load_in = (rd_size != DM_NONE);
    assign size_in    = is_load_in ? rd_size : wr_size;
    assign has_op     = (size_in != DM_NONE);

`ifdef MISALIGN_TRAP_EN
    assign misaligned_in = has_op && is_misaligned(size_in, address[1:0]);
`else
    assign misaligned_in = 1'b0;
`endif

    // Store lanes: replicate the datum across the word, enable only the addressed bytes.
    for (genvar gi = 0; gi < 4; gi++) begin : g_store_lane
        localparam logic [1:0] LANE = 2'(gi);
        assign wdata_in[8*gi +: 8] = (size_in == DM_BYTE)  ? store_data[7:0] :
                                     (size_in == DM_HWORD) ? store_data[8*(gi%2) +: 8] :
                                                             store_data[8*gi +: 8];
        assign wstrb_in[gi] = !is_load_in &&
                              ((size_in == DM_WORD) ||
                               ((size_in == DM_HWORD) && (address[1] == LANE[1])) ||
                               ((size_in == DM_BYTE)  && (address[1:0] == LANE)));
    end

    assign timeout_hit = (state_reg == MAU_ACCESS) && !mem_ready && (TIMEOUT_CYCLES != 0) &&
                         ((wait_cnt_reg + CNT_W'(1)) == TIMEOUT_LIM);

    memory_access_unit_load_align u_load_align (
        .rdata       (mem_rdata),
        .offset      (req_reg.offset),
        .size        (req_reg.size),
        .load_signed (req_reg.load_signed),
        .result      (aligned_result)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= MAU_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            MAU_IDLE: begin
                if (start) begin
                    state_next = (!has_op || misaligned_in) ? MAU_RESP : MAU_ACCESS;
                end
            end
            MAU_ACCESS: begin
                if (mem_ready || timeout_hit) begin
                    state_next = MAU_RESP;
                end
            end
            MAU_RESP: state_next = MAU_IDLE;
            default:  state_next = MAU_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            req_reg       <= '0;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
            mem_wstrb_reg <= '0;
            load_data_reg <= '0;
            err_reg       <= 1'b0;
            wait_cnt_reg  <= '0;
        end else begin
            case (state_reg)
                MAU_IDLE: begin
                    if (start) begin
                        wait_cnt_reg <= '0;
                        err_reg      <= misaligned_in;
                        req_reg      <= '{is_load:     is_load_in,
                                          size:        size_in,
                                          load_signed: load_signed,
                                          offset:      address[1:0]};
                        if (has_op && !misaligned_in) begin
                            mem_we_reg    <= !is_load_in;
                            mem_addr_reg  <= {address[ADDR_WIDTH-1:2], 2'b00};
                            mem_wdata_reg <= is_load_in ? 32'd0 : wdata_in;
                            mem_wstrb_reg <= wstrb_in;
                        end
                        if (misaligned_in) begin
                            load_data_reg <= '0;
                        end
                    end
                end
                MAU_ACCESS: begin
                    if (mem_ready) begin
                        if (req_reg.is_load) begin
                            load_data_reg <= aligned_result;
                        end
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + CNT_W'(1);
                        if (timeout_hit) begin
                            err_reg       <= 1'b1;
                            load_data_reg <= '0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        mem_req   = (state_reg == MAU_ACCESS);
        done      = (state_reg == MAU_RESP);
        busy      = (state_reg != MAU_IDLE);
        bus_error = (state_reg == MAU_RESP) && err_reg;
        mem_we    = mem_we_reg;
        mem_addr  = mem_addr_reg;
        mem_wdata = mem_wdata_reg;
        mem_wstrb = mem_wstrb_reg;
        load_data = load_data_reg;
    end

endmodule

// File: tb/tb_memory_access_unit.sv
// Directed bench for memory_access_unit: loads, stores, NONE op, timeout,
// reset abort and the misaligned word access (behaviour follows MISALIGN_TRAP_EN).
module tb_memory_access_unit;
    import memory_access_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst, start, load_signed, mem_req, mem_we, mem_ready, done, busy, bus_error;
    logic [1:0]  read_status, write_status;
    logic [31:0] address, store_data, mem_addr, mem_wdata, mem_rdata, load_data;
    logic [3:0]  mem_wstrb;
    int          checks = 0;
    int          passes = 0;
    int          req_cycles;

    always #5 clk = ~clk;

    memory_access_unit #(.TIMEOUT_CYCLES(4), .ADDR_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .read_status(read_status),
        .write_status(write_status), .load_signed(load_signed), .address(address),
        .store_data(store_data), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ready(mem_ready),
        .mem_rdata(mem_rdata), .load_data(load_data), .done(done), .busy(busy),
        .bus_error(bus_error)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic issue(input logic [1:0] rs, input logic [1:0] ws, input logic sg,
                         input logic [31:0] a, input logic [31:0] sd);
        @(negedge clk);
        read_status = rs; write_status = ws; load_signed = sg;
        address = a; store_data = sd; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic respond(input string tag, input int waits, input logic [31:0] rd);
        for (int i = 0; i < waits; i++) begin
            check({tag, "_req_wait"}, mem_req, 1);
            @(negedge clk);
        end
        mem_ready = 1'b1; mem_rdata = rd;
        @(negedge clk);
        mem_ready = 1'b0; mem_rdata = 32'd0;
    endtask

    task automatic complete(input string tag, input logic err, input logic [31:0] ld);
        check({tag, "_done"}, done, 1);
        check({tag, "_req_low"}, mem_req, 0);
        check({tag, "_bus_error"}, bus_error, err);
        check({tag, "_load_data"}, load_data, ld);
        @(negedge clk);
        check({tag, "_done_pulse"}, done, 0);
        check({tag, "_idle"}, busy, 0);
        $display("txn %s: load_data=0x%08h bus_error=%0b", tag, load_data, err);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; read_status = DM_NONE; write_status = DM_NONE;
        load_signed = 1'b0; address = 32'd0; store_data = 32'd0;
        mem_ready = 1'b0; mem_rdata = 32'd0;
        repeat (2) @(negedge clk);
        check("rst_req", mem_req, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", bus_error, 0);
        check("rst_load", load_data, 0);
        check("rst_wstrb", mem_wstrb, 0);
        check("rst_addr", mem_addr, 0);
        rst = 1'b0;

        // lb signed, byte 3, two wait states
        issue(DM_BYTE, DM_NONE, 1'b1, 32'h103, 32'd0);
        check("lb_busy", busy, 1);
        check("lb_req", mem_req, 1);
        check("lb_addr", mem_addr, 32'h100);
        check("lb_we", mem_we, 0);
        check("lb_wstrb", mem_wstrb, 4'b0000);
        respond("lb", 2, 32'h80FF_1234);
        complete("lb", 1'b0, 32'hFFFF_FF80);

        issue(DM_HWORD, DM_NONE, 1'b0, 32'h202, 32'd0);
        check("lhu_addr", mem_addr, 32'h200);
        respond("lhu", 0, 32'hBEEF_0001);
        complete("lhu", 1'b0, 32'h0000_BEEF);

        issue(DM_HWORD, DM_NONE, 1'b1, 32'h202, 32'd0);
        respond("lh", 0, 32'hBEEF_0001);
        complete("lh", 1'b0, 32'hFFFF_BEEF);

        issue(DM_NONE, DM_BYTE, 1'b0, 32'h301, 32'h1234_56AB);
        check("sb_we", mem_we, 1);
        check("sb_addr", mem_addr, 32'h300);
        check("sb_wdata", mem_wdata, 32'hABAB_ABAB);
        check("sb_wstrb", mem_wstrb, 4'b0010);
        respond("sb", 1, 32'hFFFF_FFFF);
        complete("sb", 1'b0, 32'hFFFF_BEEF);

        issue(DM_NONE, DM_HWORD, 1'b0, 32'h302, 32'h0000_BEEF);
        check("sh_wdata", mem_wdata, 32'hBEEF_BEEF);
        check("sh_wstrb", mem_wstrb, 4'b1100);
        respond("sh", 0, 32'd0);
        complete("sh", 1'b0, 32'hFFFF_BEEF);

        issue(DM_NONE, DM_WORD, 1'b0, 32'h300, 32'h1234_56AB);
        check("sw_wdata", mem_wdata, 32'h1234_56AB);
        check("sw_wstrb", mem_wstrb, 4'b1111);
        respond("sw", 0, 32'd0);
        complete("sw", 1'b0, 32'hFFFF_BEEF);

        // load and store both requested: load wins
        issue(DM_WORD, DM_WORD, 1'b1, 32'h500, 32'hDEAD_BEEF);
        check("both_we", mem_we, 0);
        check("both_wstrb", mem_wstrb, 4'b0000);
        respond("both", 0, 32'h0102_0304);
        complete("both", 1'b0, 32'h0102_0304);

        issue(DM_BYTE, DM_NONE, 1'b0, 32'h001, 32'd0);
        respond("lbu", 0, 32'h1234_8056);
        complete("lbu", 1'b0, 32'h0000_0080);

        // NONE/NONE: done the cycle after start, no bus activity
        issue(DM_NONE, DM_NONE, 1'b0, 32'h900, 32'd0);
        check("none_busy", busy, 1);
        complete("none", 1'b0, 32'h0000_0080);

        // timeout with mem_ready never asserted
        issue(DM_WORD, DM_NONE, 1'b0, 32'h600, 32'd0);
        req_cycles = 0;
        while (mem_req && req_cycles < 20) begin
            req_cycles++;
            @(negedge clk);
        end
        check("to_req_cycles", req_cycles, 4);
        complete("timeout", 1'b1, 32'd0);

        // start while busy must not disturb the access in flight
        issue(DM_WORD, DM_NONE, 1'b0, 32'h700, 32'd0);
        address = 32'h800; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_start_addr", mem_addr, 32'h700);
        respond("busy_start", 0, 32'h5555_AAAA);
        complete("busy_start", 1'b0, 32'h5555_AAAA);

        // reset in ACCESS aborts with no done, then a fresh access completes
        issue(DM_WORD, DM_NONE, 1'b0, 32'h10, 32'd0);
        check("rstmid_req", mem_req, 1);
        rst = 1'b1;
        @(negedge clk);
        check("rstmid_req_low", mem_req, 0);
        check("rstmid_busy", busy, 0);
        check("rstmid_done", done, 0);
        rst = 1'b0;
        @(negedge clk);
        check("rstmid_no_done", done, 0);
        issue(DM_WORD, DM_NONE, 1'b0, 32'h10, 32'd0);
        respond("after_rst", 0, 32'h1122_3344);
        complete("after_rst", 1'b0, 32'h1122_3344);

        // misaligned word access
        issue(DM_WORD, DM_NONE, 1'b0, 32'h402, 32'd0);
`ifdef MISALIGN_TRAP_EN
        complete("mis_trap", 1'b1, 32'd0);
`else
        check("mis_addr", mem_addr, 32'h400);
        check("mis_req", mem_req, 1);
        respond("mis", 0, 32'hCAFE_BABE);
        complete("mis", 1'b0, 32'hCAFE_BABE);
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
